// File: rtl/pwm_fader.sv
// Multi-channel LED PWM engine: per-channel linear fade, quadratic gamma, double-buffered duty.
// Optional macro PWM_FADER_PHASE_STAGGER_EN offsets each channel's compare phase.
module pwm_fader #(
    parameter int CHANNELS      = 3,
    parameter int IN_BITS       = 8,
    parameter int PWM_BITS      = 11,
    parameter int PRESCALE_BITS = 13,
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [7:0]          fade_rate,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [CW-1:0]       wr_chan,
    input  logic [IN_BITS-1:0]  wr_level,
    input  logic                wr_instant,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_start,
    output logic                busy
);

    localparam int SH  = 2*IN_BITS - PWM_BITS;
    localparam int PW  = PRESCALE_BITS + 8;
    localparam int OFF = (1 << PWM_BITS) / CHANNELS;
    localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

    logic [PW-1:0]         r_pre;
    logic                  r_rdy;
    logic                  w_tick;
    logic                  w_wr;
    logic [IN_BITS-1:0]    r_cur    [CHANNELS];
    logic [IN_BITS-1:0]    r_tgt    [CHANNELS];
    logic [CW-1:0]         r_ptr;
    logic [CW-1:0]         r_sptr;
    logic [IN_BITS-1:0]    r_samp;
    logic [IN_BITS-1:0]    w_samp;
    logic [2*IN_BITS-1:0]  w_sq;
    logic [PWM_BITS-1:0]   r_shadow [CHANNELS];
    logic [PWM_BITS-1:0]   r_duty   [CHANNELS];
    logic [CHANNELS-1:0]   r_full;
    logic [CHANNELS-1:0]   r_fullreg;
    logic [PWM_BITS-1:0]   r_cnt;
    logic                  r_wrap;
    logic                  r_ps;
    logic                  r_busy;
    logic                  w_busy;
    logic [CHANNELS-1:0]   r_pwm;
    logic [CHANNELS-1:0]   w_pwm;

    // Writes are held off on tick cycles so fade and write never race on cur.
    assign w_tick   = r_pre[PW-1:PRESCALE_BITS] > fade_rate;
    assign wr_ready = r_rdy & ~w_tick;
    assign w_wr     = wr_valid & wr_ready;

    assign pwm_out      = r_pwm;
    assign period_start = r_ps;
    assign busy         = r_busy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pre <= '0;
            r_rdy <= 1'b0;
        end else begin
            r_rdy <= 1'b1;
            if (w_tick) begin
                r_pre <= '0;
            end else begin
                r_pre <= r_pre + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_cur[i] <= '0;
                r_tgt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_tick) begin
                    if (r_cur[i] < r_tgt[i]) begin
                        r_cur[i] <= r_cur[i] + IN_BITS'(1);
                    end else if (r_cur[i] > r_tgt[i]) begin
                        r_cur[i] <= r_cur[i] - IN_BITS'(1);
                    end
                end else if (w_wr && int'(wr_chan) == i) begin
                    r_tgt[i] <= wr_level;
                    if (wr_instant) begin
                        r_cur[i] <= wr_level;
                    end
                end
            end
        end
    end

    always_comb begin
        w_samp = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (int'(r_ptr) == i) begin
                w_samp = r_cur[i];
            end
        end
    end

    assign w_sq = {{IN_BITS{1'b0}}, r_samp} * {{IN_BITS{1'b0}}, r_samp};

    // Single squarer shared round-robin: sample one cycle, write shadow the next.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr  <= '0;
            r_sptr <= '0;
            r_samp <= '0;
            r_full <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            r_ptr  <= (int'(r_ptr) == CHANNELS - 1) ? '0 : r_ptr + CW'(1);
            r_sptr <= r_ptr;
            r_samp <= w_samp;
            for (int i = 0; i < CHANNELS; i++) begin
                if (int'(r_sptr) == i) begin
                    r_shadow[i] <= PWM_BITS'(w_sq >> SH);
                    r_full[i]   <= &r_samp;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_wrap    <= 1'b0;
            r_ps      <= 1'b0;
            r_fullreg <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_duty[i] <= '0;
            end
        end else begin
            r_cnt  <= r_cnt + PWM_BITS'(1);
            r_wrap <= (r_cnt == CNT_MAX);
            r_ps   <= r_wrap;
            if (r_cnt == CNT_MAX) begin
                r_fullreg <= r_full;
                for (int i = 0; i < CHANNELS; i++) begin
                    r_duty[i] <= r_shadow[i];
                end
            end
        end
    end

    always_comb begin
        w_pwm  = '0;
        w_busy = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
`ifdef PWM_FADER_PHASE_STAGGER_EN
            w_pwm[i] = enable & (r_fullreg[i] |
                       ((r_cnt + PWM_BITS'(i * OFF)) < r_duty[i]));
`else
            w_pwm[i] = enable & (r_fullreg[i] | (r_cnt < r_duty[i]));
`endif
            w_busy = w_busy | (r_cur[i] != r_tgt[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pwm  <= '0;
            r_busy <= 1'b0;
        end else begin
            r_pwm  <= w_pwm;
            r_busy <= w_busy;
        end
    end

endmodule

// File: doc/pwm_fader.md
Name: pwm_fader

Overview:
- Multi-channel LED PWM engine; parametrised successor to the fixed 3-channel 8-to-11-bit map-and-compare driver.
- Per channel: target brightness written over a valid/ready port, linear fade of the current level toward the target at a programmable rate, and a quadratic gamma map to PWM duty.
- Duty values are double-buffered so a PWM period is never glitched mid-cycle.
- Sits between control logic (breathing/status FSMs) and the LED pad drivers.

Parameters:
- CHANNELS, 3, number of independent PWM channels (1..16).
- IN_BITS, 8, width of brightness level.
- PWM_BITS, 11, width of PWM counter/duty; must satisfy IN_BITS <= PWM_BITS <= 2*IN_BITS.
- PRESCALE_BITS, 13, low bits of the fade prescaler ignored when compared with fade_rate.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  0 forces all pwm_out low; counters and fades keep running.
- fade_rate  in  8  fade tick period; a tick fires when prescaler[PRESCALE_BITS+7:PRESCALE_BITS] > fade_rate.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- wr_chan  in  $clog2(CHANNELS) (min 1)  target channel.
- wr_level  in  IN_BITS  new target level.
- wr_instant  in  1  1 sets cur=tgt=wr_level with no fade.
- pwm_out  out  CHANNELS  PWM outputs, bit i = channel i.
- period_start  out  1  one-cycle pulse when the PWM counter wraps to 0.
- busy  out  1  high while any channel has cur != tgt.

Behaviour:
- Reset: all cur, tgt, duty and shadow registers 0; PWM counter 0; prescaler 0; scan pointer 0. pwm_out=0, period_start=0, busy=0, wr_ready=0 while reset_n is low and 1 from the first clock after release.
- Prescaler: PRESCALE_BITS+8 bits. When the tick condition holds, prescaler <= 0 and tick=1 for that cycle; otherwise it increments. Tick period is (fade_rate+1)*2^PRESCALE_BITS + 1 cycles.
- Fade, on a tick cycle: every channel with cur<tgt increments cur by 1; cur>tgt decrements by 1; cur==tgt holds. A fade never overshoots and never wraps.
- wr_ready is 0 on tick cycles. A write and a tick never coincide.
- Accepted write: tgt[wr_chan] <= wr_level. If wr_instant=1, cur[wr_chan] is also set to wr_level. wr_chan >= CHANNELS is accepted and ignored.
- Gamma map: one time-shared squarer with a scan pointer cycling 0..CHANNELS-1, one channel per cycle.
  - Cycle n: sample cur[ptr].
  - Cycle n+1: shadow[ptr] <= (cur*cur) >> (2*IN_BITS-PWM_BITS), plus full[ptr] <= (cur == all-ones).
  - Worst-case cur-to-shadow latency: CHANNELS+1 cycles.
- Duty load: on the cycle the PWM counter equals 2^PWM_BITS-1, duty[i] <= shadow[i] and fullreg[i] <= full[i] for all i. The new duty takes effect at counter 0.
- Compare, registered: pwm_out[i] <= enable && (fullreg[i] || counter < duty[i]).
  - Level 0 gives a constant 0.
  - Full scale gives a constant 1 with no off-cycle.
- period_start is registered; it is high in the cycle after the counter goes from max to 0, aligned with the first pwm_out of the new period.
- busy is registered: OR over all channels of (cur != tgt).
- reset_n asserted mid-fade or mid-period: all state clears immediately (asynchronously); no partial duty is held.

Optional Feature:
- Macro: PWM_FADER_PHASE_STAGGER_EN.
- Defined: channel i compares against (counter + i*(2^PWM_BITS/CHANNELS)) mod 2^PWM_BITS. This spreads turn-on edges to cut peak supply current. Duty load and period_start still follow the unoffset counter.
- Undefined: all channels compare against the same counter; all rising edges align at counter 0.

Test Plan:
- Reset release, no writes, defaults -> pwm_out=0, busy=0, period_start pulses every 2048 cycles, wr_ready=1 from first post-reset clock.
- Write ch1 level 255 instant -> within one PWM period of the next wrap, pwm_out[1] is constant 1 for a full 2048-cycle period; ch0/ch2 remain 0.
- Write ch0 level 128 instant -> duty = (128*128)>>5 = 512; pwm_out[0] high for exactly 512 of each 2048 cycles after the next period boundary.
- fade_rate=0, ch2 from 0, write level 4 non-instant -> busy=1; cur steps 1,2,3,4 on four successive ticks 8193 cycles apart; busy drops on the cycle after cur reaches 4; no overshoot.
- Hold wr_valid across a tick cycle -> wr_ready=0 on exactly that cycle; the write lands the next cycle; no lost or duplicated write.
- Assert reset_n low mid-fade with pwm_out[0] high -> pwm_out, busy and period_start go 0 without waiting for clk; after release all channels restart from 0.
